// File: rtl/pzcorebus_default_responder.sv
// pzcorebus default responder (memory-H profile).
// Terminates commands that missed every decoder window: accepts each command, drains any write
// data and answers reads and non-posted writes with error responses.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_mcmd_valid / o_scmd_accept       command handshake (i_mcmd, i_mid, i_mlength)
//   i_mdata_valid / o_sdata_accept     write data handshake (i_mdata_last; data/byteen discarded)
//   o_sresp_valid / i_mresp_accept     response handshake (o_sresp, o_sid, o_serror, o_sdata,
//                                      o_sresp_last)
//   o_error_count                      saturating count of accepted commands
module pzcorebus_default_responder #(
  parameter int unsigned            ID_WIDTH     = 8,
  parameter int unsigned            DATA_WIDTH   = 64,
  parameter int unsigned            LENGTH_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]  ERROR_DATA   = '1,
  parameter int unsigned            COUNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mcmd_valid,
  output logic                    o_scmd_accept,
  input  logic [1:0]              i_mcmd,
  input  logic [ID_WIDTH-1:0]     i_mid,
  input  logic [LENGTH_WIDTH-1:0] i_mlength,
  input  logic                    i_mdata_valid,
  output logic                    o_sdata_accept,
  input  logic                    i_mdata_last,
  input  logic [DATA_WIDTH-1:0]   i_mdata,
  input  logic [DATA_WIDTH/8-1:0] i_mdata_byteen,
  output logic                    o_sresp_valid,
  input  logic                    i_mresp_accept,
  output logic                    o_sresp,
  output logic [ID_WIDTH-1:0]     o_sid,
  output logic                    o_serror,
  output logic [DATA_WIDTH-1:0]   o_sdata,
  output logic [1:0]              o_sresp_last,
  output logic [COUNT_WIDTH-1:0]  o_error_count
);

  typedef enum logic [1:0] {StIdle, StWdata, StResp} state_e;

  localparam logic [1:0] CmdRead  = 2'd0;
  localparam logic [1:0] CmdWrite = 2'd1;
  localparam logic [1:0] CmdWrNp  = 2'd2;

  state_e                  state_q;
  logic                    scmd_accept_q;
  logic                    sdata_accept_q;
  logic                    sresp_valid_q;
  logic                    sresp_q;
  logic [ID_WIDTH-1:0]     sid_q;
  logic [DATA_WIDTH-1:0]   sdata_q;
  logic [1:0]              sresp_last_q;
  logic [LENGTH_WIDTH-1:0] beat_cnt_q;
  logic                    np_q;
  logic [COUNT_WIDTH-1:0]  error_count_q;

  // Write payload is intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^{i_mdata, i_mdata_byteen};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      scmd_accept_q  <= 1'b1;
      sdata_accept_q <= 1'b0;
      sresp_valid_q  <= 1'b0;
      sresp_q        <= 1'b0;
      sid_q          <= '0;
      sdata_q        <= '0;
      sresp_last_q   <= 2'b00;
      beat_cnt_q     <= '0;
      np_q           <= 1'b0;
      error_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_mcmd_valid && scmd_accept_q) begin
            if (~&error_count_q) error_count_q <= error_count_q + COUNT_WIDTH'(1);
            if (i_mcmd == CmdRead) begin
              state_q       <= StResp;
              scmd_accept_q <= 1'b0;
              sresp_valid_q <= 1'b1;
              sresp_q       <= 1'b1;
              sid_q         <= i_mid;
              sdata_q       <= ERROR_DATA;
              // Length 0 wraps to all-ones, giving 2**LENGTH_WIDTH beats.
              beat_cnt_q    <= i_mlength - LENGTH_WIDTH'(1);
              sresp_last_q  <= (i_mlength == LENGTH_WIDTH'(1)) ? 2'b11 : 2'b00;
            end else if (i_mcmd == CmdWrite || i_mcmd == CmdWrNp) begin
              state_q        <= StWdata;
              scmd_accept_q  <= 1'b0;
              sdata_accept_q <= 1'b1;
              sid_q          <= i_mid;
              np_q           <= (i_mcmd == CmdWrNp);
            end
            // Messages are posted and need no response.
          end
        end
        StWdata: begin
          if (i_mdata_valid && sdata_accept_q && i_mdata_last) begin
            sdata_accept_q <= 1'b0;
            if (np_q) begin
              state_q       <= StResp;
              sresp_valid_q <= 1'b1;
              sresp_q       <= 1'b0;
              sdata_q       <= '0;
              beat_cnt_q    <= '0;
              sresp_last_q  <= 2'b11;
            end else begin
              state_q       <= StIdle;
              scmd_accept_q <= 1'b1;
            end
          end
        end
        StResp: begin
          if (i_mresp_accept) begin
            if (beat_cnt_q == '0) begin
              state_q       <= StIdle;
              scmd_accept_q <= 1'b1;
              sresp_valid_q <= 1'b0;
              sresp_last_q  <= 2'b00;
            end else begin
              beat_cnt_q   <= beat_cnt_q - LENGTH_WIDTH'(1);
              sresp_last_q <= (beat_cnt_q == LENGTH_WIDTH'(1)) ? 2'b11 : 2'b00;
            end
          end
        end
        default: begin
          state_q        <= StIdle;
          scmd_accept_q  <= 1'b1;
          sdata_accept_q <= 1'b0;
          sresp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_scmd_accept  = scmd_accept_q;
  assign o_sdata_accept = sdata_accept_q;
  assign o_sresp_valid  = sresp_valid_q;
  assign o_sresp        = sresp_q;
  assign o_sid          = sid_q;
  assign o_serror       = sresp_valid_q;
  assign o_sdata        = sdata_q;
  assign o_sresp_last   = sresp_last_q;
  assign o_error_count  = error_count_q;

endmodule

// File: tb/tb_pzcorebus_default_responder.sv
// Directed self-checking bench for pzcorebus_default_responder (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pzcorebus_default_responder;

  localparam logic [63:0] ErrData = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mcmd_valid = 1'b0;
  logic        scmd_accept;
  logic [1:0]  mcmd = 2'd0;
  logic [7:0]  mid = 8'd0;
  logic [3:0]  mlength = 4'd0;
  logic        mdata_valid = 1'b0;
  logic        sdata_accept;
  logic        mdata_last = 1'b0;
  logic [63:0] mdata = 64'h0123_4567_89AB_CDEF;
  logic [7:0]  mdata_byteen = 8'hFF;
  logic        sresp_valid;
  logic        mresp_accept = 1'b0;
  logic        sresp;
  logic [7:0]  sid;
  logic        serror;
  logic [63:0] sdata;
  logic [1:0]  sresp_last;
  logic [15:0] error_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pzcorebus_default_responder dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mcmd_valid   (mcmd_valid),
    .o_scmd_accept  (scmd_accept),
    .i_mcmd         (mcmd),
    .i_mid          (mid),
    .i_mlength      (mlength),
    .i_mdata_valid  (mdata_valid),
    .o_sdata_accept (sdata_accept),
    .i_mdata_last   (mdata_last),
    .i_mdata        (mdata),
    .i_mdata_byteen (mdata_byteen),
    .o_sresp_valid  (sresp_valid),
    .i_mresp_accept (mresp_accept),
    .o_sresp        (sresp),
    .o_sid          (sid),
    .o_serror       (serror),
    .o_sdata        (sdata),
    .o_sresp_last   (sresp_last),
    .o_error_count  (error_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge with scmd_accept high; returns on the falling edge after transfer.
  task automatic issue(input logic [1:0] cmd, input logic [7:0] id, input logic [3:0] len);
    mcmd_valid = 1'b1;
    mcmd       = cmd;
    mid        = id;
    mlength    = len;
    @(negedge clk);
    mcmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    check_eq("rst_valid", 64'(sresp_valid), 64'd0);
    check_eq("rst_cmd_acc", 64'(scmd_accept), 64'd1);
    check_eq("rst_data_acc", 64'(sdata_accept), 64'd0);
    check_eq("rst_last", 64'(sresp_last), 64'd0);
    check_eq("rst_sid", 64'(sid), 64'd0);
    check_eq("rst_sdata", sdata, 64'd0);
    check_eq("rst_count", 64'(error_count), 64'd0);

    // READ mid=5 len=3, accept tied high: three consecutive beats, last on the third
    mresp_accept = 1'b1;
    issue(2'd0, 8'd5, 4'd3);
    for (int b = 0; b < 3; b++) begin
      check_eq("rd3_valid", 64'(sresp_valid), 64'd1);
      check_eq("rd3_sid", 64'(sid), 64'd5);
      check_eq("rd3_serror", 64'(serror), 64'd1);
      check_eq("rd3_sresp", 64'(sresp), 64'd1);
      check_eq("rd3_sdata", sdata, ErrData);
      check_eq("rd3_last", 64'(sresp_last), (b == 2) ? 64'd3 : 64'd0);
      check_eq("rd3_cmd_acc", 64'(scmd_accept), 64'd0);
      @(negedge clk);
    end
    check_eq("rd3_done_valid", 64'(sresp_valid), 64'd0);
    check_eq("rd3_done_cmd_acc", 64'(scmd_accept), 64'd1);
    check_eq("rd3_count", 64'(error_count), 64'd1);

    // READ len=0: sixteen beats, only the sixteenth marked last
    issue(2'd0, 8'd6, 4'd0);
    for (int b = 0; b < 16; b++) begin
      check_eq("rd16_valid", 64'(sresp_valid), 64'd1);
      check_eq("rd16_last", 64'(sresp_last), (b == 15) ? 64'd3 : 64'd0);
      @(negedge clk);
    end
    check_eq("rd16_done_valid", 64'(sresp_valid), 64'd0);
    check_eq("rd16_count", 64'(error_count), 64'd2);

    // Non-posted write mid=9, first data beat presented together with the command
    mdata_valid = 1'b1;
    mdata_last  = 1'b0;
    issue(2'd2, 8'd9, 4'd0);
    check_eq("np_data_acc", 64'(sdata_accept), 64'd1);
    check_eq("np_cmd_acc", 64'(scmd_accept), 64'd0);
    for (int b = 1; b <= 4; b++) begin
      mdata_last = (b == 4);
      @(negedge clk);
      check_eq("np_valid", 64'(sresp_valid), (b == 4) ? 64'd1 : 64'd0);
    end
    mdata_valid = 1'b0;
    mdata_last  = 1'b0;
    check_eq("np_sresp", 64'(sresp), 64'd0);
    check_eq("np_sid", 64'(sid), 64'd9);
    check_eq("np_serror", 64'(serror), 64'd1);
    check_eq("np_sdata", sdata, 64'd0);
    check_eq("np_last", 64'(sresp_last), 64'd3);
    check_eq("np_data_acc_off", 64'(sdata_accept), 64'd0);
    @(negedge clk);
    check_eq("np_done_valid", 64'(sresp_valid), 64'd0);
    check_eq("np_done_cmd_acc", 64'(scmd_accept), 64'd1);
    check_eq("np_count", 64'(error_count), 64'd3);

    // Posted write of two beats, then a message: never any response
    do_reset();
    issue(2'd1, 8'd1, 4'd0);
    check_eq("pw_valid0", 64'(sresp_valid), 64'd0);
    mdata_valid = 1'b1;
    for (int b = 1; b <= 2; b++) begin
      mdata_last = (b == 2);
      @(negedge clk);
      check_eq("pw_valid", 64'(sresp_valid), 64'd0);
    end
    mdata_valid = 1'b0;
    mdata_last  = 1'b0;
    check_eq("pw_cmd_acc", 64'(scmd_accept), 64'd1);
    issue(2'd3, 8'd2, 4'd0);
    check_eq("msg_valid", 64'(sresp_valid), 64'd0);
    check_eq("msg_cmd_acc", 64'(scmd_accept), 64'd1);
    @(negedge clk);
    check_eq("msg_valid_late", 64'(sresp_valid), 64'd0);
    check_eq("pw_count", 64'(error_count), 64'd2);

    // READ len=2 with response accept held low for five cycles
    mresp_accept = 1'b0;
    issue(2'd0, 8'd7, 4'd2);
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_valid", 64'(sresp_valid), 64'd1);
      check_eq("stall_sid", 64'(sid), 64'd7);
      check_eq("stall_sresp", 64'(sresp), 64'd1);
      check_eq("stall_sdata", sdata, ErrData);
      check_eq("stall_last", 64'(sresp_last), 64'd0);
      check_eq("stall_cmd_acc", 64'(scmd_accept), 64'd0);
      @(negedge clk);
    end
    mresp_accept = 1'b1;
    @(negedge clk);
    check_eq("stall_last2", 64'(sresp_last), 64'd3);
    check_eq("stall_valid2", 64'(sresp_valid), 64'd1);
    @(negedge clk);
    check_eq("stall_done", 64'(sresp_valid), 64'd0);
    check_eq("stall_count", 64'(error_count), 64'd3);

    // Reset during a four-beat read, then a fresh single-beat read
    issue(2'd0, 8'd3, 4'd4);
    check_eq("mid_rst_beat1", 64'(sresp_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(sresp_valid), 64'd0);
    check_eq("mid_rst_cmd_acc", 64'(scmd_accept), 64'd1);
    check_eq("mid_rst_count", 64'(error_count), 64'd0);
    issue(2'd0, 8'd2, 4'd1);
    check_eq("post_rst_valid", 64'(sresp_valid), 64'd1);
    check_eq("post_rst_sid", 64'(sid), 64'd2);
    check_eq("post_rst_last", 64'(sresp_last), 64'd3);
    @(negedge clk);
    check_eq("post_rst_done", 64'(sresp_valid), 64'd0);
    check_eq("post_rst_count", 64'(error_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
